// File: rtl/fixed_encoder_n.sv
// FLAC fixed-predictor encoder: per-block order 0..MAX_ORDER, warm-up samples passed
// through verbatim, then signed residuals, registered with one cycle of latency.
module fixed_encoder_n #(
   parameter int SAMPLE_W  = 16,
   parameter int MAX_ORDER = 4,
   parameter int RES_W     = SAMPLE_W + 4
) (
   input  logic                       iClock,
   input  logic                       iReset,
   input  logic                       iEnable,
   input  logic                       iBlockStart,
   input  logic [2:0]                 iOrder,
   input  logic signed [SAMPLE_W-1:0] iSample,
   output logic signed [RES_W-1:0]    oData,
   output logic                       oValid,
   output logic                       oWarmup
);

   localparam logic [2:0] maxOrd  = 3'(MAX_ORDER);
   localparam logic [2:0] warmSat = 3'd4;

   logic signed [SAMPLE_W-1:0] x1, x2, x3, x4;
   logic        [2:0]          ordReg, warmCnt;
   logic        [2:0]          effOrd, effCnt, nextCnt;
   logic                       isWarm;
   logic signed [RES_W-1:0]    s0, s1, s2, s3, s4;
   logic signed [RES_W-1:0]    residual, nextData;

   // Sign-extend the current sample and history into the wide residual domain.
   assign s0 = RES_W'(iSample);
   assign s1 = RES_W'(x1);
   assign s2 = RES_W'(x2);
   assign s3 = RES_W'(x3);
   assign s4 = RES_W'(x4);

   always_comb begin
      // NOTE: every comb output gets a default first, so no path can infer a latch.
      effOrd = ordReg;
      effCnt = warmCnt;
      if (iBlockStart) begin
         effOrd = (iOrder > maxOrd) ? maxOrd : iOrder;
         effCnt = '0;
      end

      unique case (effOrd)
         3'd0:    residual = s0;
         3'd1:    residual = s0 - s1;
         3'd2:    residual = s0 - (s1 <<< 1) + s2;
         3'd3:    residual = s0 - ((s1 <<< 1) + s1) + ((s2 <<< 1) + s2) - s3;
         default: residual = s0 - (s1 <<< 2) + ((s2 <<< 2) + (s2 <<< 1)) - (s3 <<< 2) + s4;
      endcase

      // Stale history from a previous block is masked while still warming up.
      isWarm   = (effCnt < effOrd);
      nextData = isWarm ? s0 : residual;
      nextCnt  = (effCnt >= warmSat) ? warmSat : effCnt + 3'd1;
   end

   always_ff @(posedge iClock) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (iReset) begin
         oData   <= '0;
         oValid  <= 1'b0;
         oWarmup <= 1'b0;
         ordReg  <= '0;
         warmCnt <= '0;
         x1      <= '0;
         x2      <= '0;
         x3      <= '0;
         x4      <= '0;
      end else begin
         oValid <= iEnable;
         if (iEnable) begin
            ordReg  <= effOrd;
            warmCnt <= nextCnt;
            x4      <= x3;
            x3      <= x2;
            x2      <= x1;
            x1      <= iSample;
            oData   <= nextData;
            oWarmup <= isWarm;
         end
      end
   end

endmodule

// File: tb/tb_fixed_encoder_n.sv
// Directed self-checking bench for fixed_encoder_n; expected values hand-computed from
// the fixed-predictor residual formulas.
module tb_fixed_encoder_n;

   localparam int SAMPLE_W = 16;
   localparam int RES_W    = SAMPLE_W + 4;

   logic                       iClock = 1'b0;
   logic                       iReset;
   logic                       iEnable;
   logic                       iBlockStart;
   logic [2:0]                 iOrder;
   logic signed [SAMPLE_W-1:0] iSample;
   logic signed [RES_W-1:0]    oData;
   logic                       oValid;
   logic                       oWarmup;

   int checks   = 0;
   int failures = 0;

   int stim[10]  = '{20, 10, -7, -4, 8, 0, 2, -3, 1, 0};
   int expO1[10] = '{20, -10, -17, 3, 12, -8, 2, -5, 4, -1};
   int expO2[10] = '{20, 10, -7, 20, 9, -20, 10, -7, 9, -5};

   fixed_encoder_n #(.SAMPLE_W(SAMPLE_W), .MAX_ORDER(4), .RES_W(RES_W)) dut (
      .iClock(iClock),
      .iReset(iReset),
      .iEnable(iEnable),
      .iBlockStart(iBlockStart),
      .iOrder(iOrder),
      .iSample(iSample),
      .oData(oData),
      .oValid(oValid),
      .oWarmup(oWarmup)
   );

   always #5 iClock = ~iClock;

   // Apply one cycle of inputs, then settle 1 time unit past the rising edge.
   task automatic drive(input bit en, input bit bs, input logic [2:0] ord, input int s);
      iEnable     = en;
      iBlockStart = bs;
      iOrder      = ord;
      iSample     = SAMPLE_W'(s);
      @(posedge iClock);
      #1;
   endtask

   task automatic test_reset();
      logic signed [RES_W-1:0] e;
      iReset = 1'b1;
      drive(1'b1, 1'b1, 3'd2, 123);
      drive(1'b1, 1'b1, 3'd2, 77);
      checks++;
      if (oValid !== 1'b0 || oData !== '0 || oWarmup !== 1'b0) begin
         failures++;
         $display("FAIL reset_state valid=%b data=%0d warm=%b expected valid=0 data=0 warm=0",
                  oValid, oData, oWarmup);
      end
      iReset = 1'b0;
      drive(1'b1, 1'b0, 3'd4, -9);
      e = RES_W'(-9);
      checks++;
      if (oValid !== 1'b1 || oData !== e || oWarmup !== 1'b0) begin
         failures++;
         $display("FAIL reset_default_order0 valid=%b data=%0d warm=%b expected valid=1 data=%0d warm=0",
                  oValid, oData, oWarmup, e);
      end
      drive(1'b0, 1'b0, 3'd0, 0);
      checks++;
      if (oValid !== 1'b0 || oData !== e) begin
         failures++;
         $display("FAIL idle_hold valid=%b data=%0d expected valid=0 data=%0d", oValid, oData, e);
      end
   endtask

   task automatic test_order(input logic [2:0] ord, input string name);
      logic signed [RES_W-1:0] e;
      logic                    w;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, i == 0, ord, stim[i]);
         case (ord)
            3'd0:    e = RES_W'(stim[i]);
            3'd1:    e = RES_W'(expO1[i]);
            default: e = RES_W'(expO2[i]);
         endcase
         w = (i < int'(ord));
         checks++;
         if (oValid !== 1'b1 || oData !== e || oWarmup !== w) begin
            failures++;
            $display("FAIL %s[%0d] valid=%b data=%0d warm=%b expected valid=1 data=%0d warm=%b",
                     name, i, oValid, oData, oWarmup, e, w);
         end
      end
   endtask

   task automatic test_order4_extreme();
      int samp[6] = '{32767, -32768, 32767, -32768, 32767, -32768};
      int expv[6] = '{32767, -32768, 32767, -32768, 524280, -524280};
      logic signed [RES_W-1:0] e;
      logic                    w;
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, i == 0, 3'd4, samp[i]);
         e = RES_W'(expv[i]);
         w = (i < 4);
         checks++;
         if (oValid !== 1'b1 || oData !== e || oWarmup !== w) begin
            failures++;
            $display("FAIL order4_extreme[%0d] valid=%b data=%0d warm=%b expected valid=1 data=%0d warm=%b",
                     i, oValid, oData, oWarmup, e, w);
         end
      end
   endtask

   task automatic test_enable_gap();
      logic signed [RES_W-1:0] e;
      for (int i = 0; i < 10; i++) begin
         if (i == 4) begin
            // Gap cycles carry a stray block start and order 0: both must be ignored.
            for (int g = 0; g < 2; g++) begin
               drive(1'b0, 1'b1, 3'd0, 99);
               e = RES_W'(20);
               checks++;
               if (oValid !== 1'b0 || oData !== e || oWarmup !== 1'b0) begin
                  failures++;
                  $display("FAIL gap[%0d] valid=%b data=%0d warm=%b expected valid=0 data=%0d warm=0",
                           g, oValid, oData, oWarmup, e);
               end
            end
         end
         // After the gap iOrder changes to 4 without a block start; it must have no effect.
         drive(1'b1, i == 0, (i < 4) ? 3'd2 : 3'd4, stim[i]);
         e = RES_W'(expO2[i]);
         checks++;
         if (oValid !== 1'b1 || oData !== e || oWarmup !== (i < 2)) begin
            failures++;
            $display("FAIL enable_gap[%0d] valid=%b data=%0d warm=%b expected valid=1 data=%0d warm=%b",
                     i, oValid, oData, oWarmup, e, (i < 2));
         end
      end
   endtask

   task automatic test_reset_midblock();
      int samp[10] = '{20, 10, -7, 5, 3, 7, 9, 1, 2, 4};
      int expv[10] = '{20, -10, -17, 5, 3, 7, 2, 1, 2, 4};
      bit wv[10]   = '{1, 0, 0, 0, 0, 1, 0, 1, 1, 1};
      logic signed [RES_W-1:0] e;
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin
            iReset = 1'b1;
            drive(1'b1, 1'b1, 3'd1, -4);
            iReset = 1'b0;
            checks++;
            if (oValid !== 1'b0 || oData !== '0 || oWarmup !== 1'b0) begin
               failures++;
               $display("FAIL midblock_reset valid=%b data=%0d warm=%b expected valid=0 data=0 warm=0",
                        oValid, oData, oWarmup);
            end
         end
         // i 0..2: order-1 block; 3..4: post-reset order 0; 5..6: new order-1 block;
         // 7..: block requesting order 7, clamped to 4.
         drive(1'b1, (i == 0) || (i == 5) || (i == 7),
               (i >= 7) ? 3'd7 : ((i >= 3 && i < 5) ? 3'd3 : 3'd1), samp[i]);
         e = RES_W'(expv[i]);
         checks++;
         if (oValid !== 1'b1 || oData !== e || oWarmup !== wv[i]) begin
            failures++;
            $display("FAIL restart[%0d] valid=%b data=%0d warm=%b expected valid=1 data=%0d warm=%b",
                     i, oValid, oData, oWarmup, e, wv[i]);
         end
      end
      // Clamped order-4 block continues: 16 - 4*8 + 6*4 - 4*2 + 1 = 1, then 32 -> 2.
      drive(1'b1, 1'b0, 3'd0, 8);
      drive(1'b1, 1'b0, 3'd0, 16);
      e = RES_W'(1);
      checks++;
      if (oValid !== 1'b1 || oData !== e || oWarmup !== 1'b0) begin
         failures++;
         $display("FAIL clamp_residual0 valid=%b data=%0d warm=%b expected valid=1 data=%0d warm=0",
                  oValid, oData, oWarmup, e);
      end
      drive(1'b1, 1'b0, 3'd0, 32);
      e = RES_W'(2);
      checks++;
      if (oValid !== 1'b1 || oData !== e || oWarmup !== 1'b0) begin
         failures++;
         $display("FAIL clamp_residual1 valid=%b data=%0d warm=%b expected valid=1 data=%0d warm=0",
                  oValid, oData, oWarmup, e);
      end
   endtask

   initial begin
      iReset      = 1'b1;
      iEnable     = 1'b0;
      iBlockStart = 1'b0;
      iOrder      = '0;
      iSample     = '0;
      test_reset();
      test_order(3'd0, "order0");
      test_order(3'd1, "order1");
      test_order(3'd2, "order2");
      test_order4_extreme();
      test_enable_gap();
      test_reset_midblock();
      drive(1'b0, 1'b0, 3'd0, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
